// File: rtl/sseg_display_ctrl_if.sv
// Shared write port of the display buffer: two independent requesters (A, B),
// each with a valid/ready handshake carrying a digit index and a 6-bit digit word.
interface sseg_display_ctrl_if;
  logic       a_valid;
  logic [2:0] a_addr;
  logic [5:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [2:0] b_addr;
  logic [5:0] b_data;
  logic       b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/sseg_display_ctrl.sv
// Eight-digit display buffer with round-robin A/B writes, sweep-clear, blinking and leading-zero blanking.
// Accepted writes show on I0..I7 one cycle later; ready is withheld during clear and reset.
module sseg_display_ctrl #(
  parameter int BLINK_TICKS = 50_000_000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sseg_display_ctrl_if.slave        wr,
  input  logic                      clear,
  input  logic [7:0]                blink_mask,
  output logic                      busy,
  output logic [5:0]                I0,
  output logic [5:0]                I1,
  output logic [5:0]                I2,
  output logic [5:0]                I3,
  output logic [5:0]                I4,
  output logic [5:0]                I5,
  output logic [5:0]                I6,
  output logic [5:0]                I7
);

  localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    dbuf_q [8];
  logic [5:0]    dbuf_d [8];
  logic          last_a_q, last_a_d;   // 1 = A was granted most recently
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          a_rdy, b_rdy;
  logic          cnt_wrap;
  logic [5:0]    w [8];
  logic          lz_run;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      last_a_q <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      for (int i = 0; i < 8; i++) dbuf_q[i] <= 6'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_a_q <= last_a_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      for (int i = 0; i < 8; i++) dbuf_q[i] <= dbuf_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_a_d = last_a_q;
    a_rdy    = 1'b0;
    b_rdy    = 1'b0;
    for (int i = 0; i < 8; i++) dbuf_d[i] = dbuf_q[i];

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          idx_d   = 3'd0;
        end else begin
          // On a tie the requester not served last time wins.
          if (wr.a_valid && (!wr.b_valid || !last_a_q)) begin
            a_rdy = 1'b1;
          end else if (wr.b_valid) begin
            b_rdy = 1'b1;
          end
          if (a_rdy) begin
            dbuf_d[wr.a_addr] = wr.a_data;
            last_a_d          = 1'b1;
          end
          if (b_rdy) begin
            dbuf_d[wr.b_addr] = wr.b_data;
            last_a_d          = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        dbuf_d[idx_q] = 6'd0;
        idx_d         = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr.a_ready = a_rdy && reset_n;
  assign wr.b_ready = b_rdy && reset_n;
  assign busy       = (state_q == ST_CLEAR);

  assign cnt_wrap = (cnt_q == CW'(BLINK_TICKS - 1));
  assign cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
  assign phase_d  = phase_q ^ cnt_wrap;

  always_comb begin
    lz_run = LZ_BLANK;
    for (int i = 0; i < 8; i++) begin
      w[i] = dbuf_q[i];
      if (phase_q && blink_mask[i]) w[i][5] = 1'b0;
    end
    // Leading zeros judged on the stored word (hex and DP), independent of enable.
    for (int i = 7; i >= 1; i--) begin
      if (lz_run && (dbuf_q[i][4:0] == 5'd0)) begin
        w[i][5] = 1'b0;
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  assign I0 = w[0];
  assign I1 = w[1];
  assign I2 = w[2];
  assign I3 = w[3];
  assign I4 = w[4];
  assign I5 = w[5];
  assign I6 = w[6];
  assign I7 = w[7];

endmodule

// File: doc/sseg_display_ctrl.md
Name: sseg_display_ctrl

Overview:
- Display-buffer controller and arbiter that feeds the eight 6-bit digit words of the 8-digit seven-segment driver.
- Two independent requesters (A, B) share the buffer through valid/ready write ports with round-robin arbitration.
- Adds a sweep-clear sequence, per-digit blinking and optional leading-zero blanking.
- Sits between system logic (counters, FSMs, CPU-side registers) and the driver's I0..I7 inputs.

Parameters:
- BLINK_TICKS, 50_000_000, clk cycles per blink half-period; legal range 2..2^26.
- LZ_BLANK, 1, 1 = enable leading-zero blanking on outputs; 0 = disable.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- a_valid  in  1  requester A write request.
- a_addr  in  3  requester A target digit index, 0..7.
- a_data  in  6  requester A digit word: [5] digit enable, [4:1] hex value, [0] DP on (active-high).
- a_ready  out  1  requester A write accepted this cycle.
- b_valid  in  1  requester B write request.
- b_addr  in  3  requester B target digit index.
- b_data  in  6  requester B digit word, same format as a_data.
- b_ready  out  1  requester B write accepted this cycle.
- clear  in  1  start sweep-clear of all eight digits.
- blink_mask  in  8  bit i = 1 makes digit i blink.
- busy  out  1  high while the clear sweep runs.
- I0..I7  out  6 each  digit words to the driver; I0 is the rightmost digit.

Behaviour:
- Storage: buf[0..7], 6 bits each. Reset sets every entry to 0, so all outputs read 0 and every digit is dark.
- FSM states:
  - IDLE: writes allowed.
  - CLEAR: sweep index idx runs 0..7. Each cycle writes buf[idx] = 0. After idx = 7 the FSM returns to IDLE, so the sweep lasts exactly 8 cycles.
- busy = (state == CLEAR).
- clear asserted in IDLE: no ready is given that cycle (clear beats writes) and the FSM enters CLEAR on the next edge. clear asserted while already in CLEAR is ignored; the sweep does not restart.
- Arbitration (IDLE only, combinational):
  - Only A valid: a_ready = 1.
  - Only B valid: b_ready = 1.
  - Both valid: grant the requester that was not granted most recently.
  - last_grant resets to B, so A wins the first tie.
  - At most one ready per cycle. ready is 0 in CLEAR, while reset_n = 0, and whenever the matching valid is 0.
- Write: on an x_valid && x_ready cycle, buf[x_addr] <= x_data at that edge, and last_grant updates. The new value is visible on the outputs the cycle after acceptance (1-cycle latency).
- Blink timer: a counter runs 0..BLINK_TICKS-1 and wraps. phase toggles on each wrap. Reset sets counter = 0 and phase = 0. The timer runs in every state.
- Output path (combinational from registers):
  - Start from w_i = buf[i].
  - If phase = 1 and blink_mask[i] = 1, force w_i[5] = 0. Hex and DP bits pass through unchanged.
  - If LZ_BLANK = 1, scan from digit 7 down toward digit 1. Force w_i[5] = 0 for each digit whose buf word has hex = 0 and DP = 0, stopping at the first digit that fails this test.
  - Digit 0 is never leading-zero blanked.
  - Digits already disabled (enable = 0) still count as leading zeros if hex = 0 and DP = 0.
  - I_i = w_i.
- Reset mid-sweep: the FSM returns to IDLE and the buffer is zeroed; no partial state remains.
- A write to the same address on consecutive cycles: the last accepted write wins.

Test Plan:
- Reset, then A writes addr 3 = 6'b1_0101_0 → a_ready = 1 in the same cycle; I3 = 6'h2A one cycle later; all other outputs stay 0.
- A and B valid together for 4 cycles (A: addr 0 / 6'h22, B: addr 1 / 6'h24) → grants go A, B, A, B; I0 = 6'h22 and I1 = 6'h24.
- Fill all digits with 6'h3F, pulse clear while A is valid → a_ready = 0 throughout the sweep; busy high for exactly 8 cycles; I0..I7 go to 0 in index order; a_ready returns the cycle after busy falls.
- BLINK_TICKS = 4, blink_mask = 8'h01, buf[0] = 6'h22 → I0 alternates 6'h22 / 6'h02 every 4 cycles; other digits are unaffected.
- LZ_BLANK = 1, buf[7..0] = 20,20,20,22,20,20,20,20 (hex) → I7..I5 = 0x00 each; I4..I0 = 22,20,20,20,20 (hex). With buf[0] = 6'h20 and all others 0x20 as well, I0 stays 6'h20.
- Assert reset_n = 0 for 1 cycle at idx = 4 mid-sweep → busy = 0 and all I = 0 on the next cycle; the next A/B tie is granted to A.
